// File: rtl/cache_arbiter_pkg.sv
// Shared types for the L1 miss-path arbiter in front of the L2 line port.
package cache_arbiter_pkg;

  localparam int unsigned LC3B_LINE_W = 128;

  typedef logic [LC3B_LINE_W-1:0] lc3b_line;
  typedef logic [15:0]            lc3b_word;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} arb_state_t;
  typedef enum logic {GRANT_I, GRANT_D} side_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of the I-cache, D-cache and L2 line-port handshakes; master is the arbiter side.
interface cache_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_address;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata;
  logic              l2_resp;

  modport master (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, l2_rdata, l2_resp,
    output i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_address, l2_wdata
  );

  modport slave (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, l2_rdata, l2_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_address, l2_wdata
  );
endinterface

// File: rtl/cache_arbiter_sat_counter16.sv
// Saturating event counter with synchronous clear (clear beats increment).
module sat_counter16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line misses onto one L2 port, one transaction at a time.
// Optional grant/conflict counters are enabled with CACHE_ARBITER_STATS_EN.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128,
  parameter bit          RR_EN  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_arbiter_if.master      bus
`ifdef CACHE_ARBITER_STATS_EN
  ,
  input  logic                 stats_clear,
  output logic [15:0]          i_grants,
  output logic [15:0]          d_grants,
  output logic [15:0]          conflicts
`endif
);

  arb_state_t        state;
  side_t             last_grant;
  logic              l2_read_q;
  logic              l2_write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              d_pend;
  logic              i_pend;
  logic              grant_d;
  logic              grant_i;

  // On a tie, D wins unless round-robin is enabled and D had the last grant.
  always_comb begin
    d_pend  = bus.d_read | bus.d_write;
    i_pend  = bus.i_read;
    grant_d = d_pend && (!i_pend || !RR_EN || (last_grant == GRANT_I));
    grant_i = i_pend && !grant_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      l2_read_q  <= 1'b0;
      l2_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_d) begin
            addr_q     <= bus.d_address;
            wdata_q    <= bus.d_wdata;
            l2_write_q <= bus.d_write;
            l2_read_q  <= !bus.d_write;
            last_grant <= GRANT_D;
            state      <= SERVE_D;
          end else if (grant_i) begin
            addr_q     <= bus.i_address;
            l2_write_q <= 1'b0;
            l2_read_q  <= 1'b1;
            last_grant <= GRANT_I;
            state      <= SERVE_I;
          end
        end
        SERVE_I, SERVE_D: begin
          if (bus.l2_resp) begin
            l2_read_q  <= 1'b0;
            l2_write_q <= 1'b0;
            state      <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.l2_read    = l2_read_q;
  assign bus.l2_write   = l2_write_q;
  assign bus.l2_address = addr_q;
  assign bus.l2_wdata   = wdata_q;
  assign bus.i_rdata    = bus.l2_rdata;
  assign bus.d_rdata    = bus.l2_rdata;
  assign bus.i_resp     = (state == SERVE_I) && bus.l2_resp;
  assign bus.d_resp     = (state == SERVE_D) && bus.l2_resp;

`ifdef CACHE_ARBITER_STATS_EN
  logic in_idle;
  assign in_idle = (state == IDLE);

  sat_counter16 #(.WIDTH(16)) u_i_grants (
    .clk(clk), .rst_n(rst_n), .clr(stats_clear), .inc(in_idle && grant_i), .count(i_grants)
  );
  sat_counter16 #(.WIDTH(16)) u_d_grants (
    .clk(clk), .rst_n(rst_n), .clr(stats_clear), .inc(in_idle && grant_d), .count(d_grants)
  );
  sat_counter16 #(.WIDTH(16)) u_conflicts (
    .clk(clk), .rst_n(rst_n), .clr(stats_clear), .inc(in_idle && d_pend && i_pend), .count(conflicts)
  );
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: RR_EN=0 and RR_EN=1 instances on shared stimulus.
// Stats counters are checked when CACHE_ARBITER_STATS_EN is defined.
module tb_cache_arbiter;
  import cache_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  logic i_read, d_read, d_write, l2_resp, stats_clear;
  logic [15:0]  i_address, d_address;
  logic [127:0] d_wdata, l2_rdata;

  int total  = 0;
  int passed = 0;

  cache_arbiter_if #(.ADDR_W(16), .LINE_W(128)) bus0 ();
  cache_arbiter_if #(.ADDR_W(16), .LINE_W(128)) bus1 ();

  assign bus0.i_read = i_read;       assign bus1.i_read = i_read;
  assign bus0.i_address = i_address; assign bus1.i_address = i_address;
  assign bus0.d_read = d_read;       assign bus1.d_read = d_read;
  assign bus0.d_write = d_write;     assign bus1.d_write = d_write;
  assign bus0.d_address = d_address; assign bus1.d_address = d_address;
  assign bus0.d_wdata = d_wdata;     assign bus1.d_wdata = d_wdata;
  assign bus0.l2_rdata = l2_rdata;   assign bus1.l2_rdata = l2_rdata;
  assign bus0.l2_resp = l2_resp;     assign bus1.l2_resp = l2_resp;

`ifdef CACHE_ARBITER_STATS_EN
  logic [15:0] ig0, dg0, cf0, ig1, dg1, cf1;
`endif

  cache_arbiter #(.ADDR_W(16), .LINE_W(128), .RR_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
`ifdef CACHE_ARBITER_STATS_EN
    , .stats_clear(stats_clear), .i_grants(ig0), .d_grants(dg0), .conflicts(cf0)
`endif
  );

  cache_arbiter #(.ADDR_W(16), .LINE_W(128), .RR_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
`ifdef CACHE_ARBITER_STATS_EN
    , .stats_clear(stats_clear), .i_grants(ig1), .d_grants(dg1), .conflicts(cf1)
`endif
  );

  logic       sat_clr, sat_inc;
  logic [3:0] sat_count;
  sat_counter16 #(.WIDTH(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(sat_clr), .inc(sat_inc), .count(sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Transaction-level reference: owner 0=none 1=I 2=D, plus a one-cycle cool-down flag.
  int           m_owner[2];
  bit           m_done[2];
  int           m_last[2];
  bit           m_opw[2];
  logic [15:0]  m_addr[2];
  logic [127:0] m_wd[2];
  int           m_ig[2], m_dg[2], m_cf[2];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic model_reset();
    for (int r = 0; r < 2; r++) begin
      m_owner[r] = 0; m_done[r] = 0; m_last[r] = 1; m_opw[r] = 0;
      m_addr[r] = '0; m_wd[r] = '0; m_ig[r] = 0; m_dg[r] = 0; m_cf[r] = 0;
    end
  endtask

  task automatic model_update();
    for (int r = 0; r < 2; r++) begin
      bit dp, ip, tie;
      int g;
      dp = d_read | d_write; ip = i_read; g = 0; tie = 0;
      if (m_owner[r] != 0) begin
        if (l2_resp) begin m_owner[r] = 0; m_done[r] = 1; end
      end else if (m_done[r]) begin
        m_done[r] = 0;
      end else begin
        tie = dp && ip;
        if (tie) g = (r == 1 && m_last[r] == 2) ? 1 : 2;
        else if (dp) g = 2;
        else if (ip) g = 1;
        if (g == 2) begin m_addr[r] = d_address; m_wd[r] = d_wdata; m_opw[r] = d_write; end
        else if (g == 1) begin m_addr[r] = i_address; m_opw[r] = 0; end
        if (g != 0) begin m_owner[r] = g; m_last[r] = g; end
      end
      if (stats_clear) begin
        m_ig[r] = 0; m_dg[r] = 0; m_cf[r] = 0;
      end else begin
        if (g == 1 && m_ig[r] < 65535) m_ig[r]++;
        if (g == 2 && m_dg[r] < 65535) m_dg[r]++;
        if (tie && m_cf[r] < 65535) m_cf[r]++;
      end
    end
  endtask

  task automatic check_dut(input int r, input logic rd, input logic wr, input logic [15:0] a,
                           input logic [127:0] wd, input logic ir, input logic dr,
                           input logic [127:0] ird, input logic [127:0] drd);
    bit busy;
    busy = (m_owner[r] != 0);
    chk($sformatf("l2_read%0d", r), rd, busy && !m_opw[r]);
    chk($sformatf("l2_write%0d", r), wr, busy && m_opw[r]);
    chk($sformatf("l2_address%0d", r), a, m_addr[r]);
    chk($sformatf("l2_wdata%0d", r), wd, m_wd[r]);
    chk($sformatf("i_resp%0d", r), ir, (m_owner[r] == 1) && l2_resp);
    chk($sformatf("d_resp%0d", r), dr, (m_owner[r] == 2) && l2_resp);
    chk($sformatf("i_rdata%0d", r), ird, l2_rdata);
    chk($sformatf("d_rdata%0d", r), drd, l2_rdata);
  endtask

  task automatic check_model();
    check_dut(0, bus0.l2_read, bus0.l2_write, bus0.l2_address, bus0.l2_wdata,
              bus0.i_resp, bus0.d_resp, bus0.i_rdata, bus0.d_rdata);
    check_dut(1, bus1.l2_read, bus1.l2_write, bus1.l2_address, bus1.l2_wdata,
              bus1.i_resp, bus1.d_resp, bus1.i_rdata, bus1.d_rdata);
`ifdef CACHE_ARBITER_STATS_EN
    chk("i_grants0", ig0, 16'(m_ig[0]));  chk("d_grants0", dg0, 16'(m_dg[0]));
    chk("conflicts0", cf0, 16'(m_cf[0])); chk("i_grants1", ig1, 16'(m_ig[1]));
    chk("d_grants1", dg1, 16'(m_dg[1]));  chk("conflicts1", cf1, 16'(m_cf[1]));
`endif
  endtask

  // Inputs are driven at posedge+1; outputs are compared at posedge+4.
  task automatic cycle_check();
    #3;
    check_model();
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task automatic clear_inputs();
    i_read = 0; d_read = 0; d_write = 0; l2_resp = 0; stats_clear = 0;
    i_address = '0; d_address = '0; d_wdata = '0; l2_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    model_reset();
    #1;
    chk("rst_l2_read", bus0.l2_read, 1'b0);
    chk("rst_l2_write", bus1.l2_write, 1'b0);
    chk("rst_l2_address", bus1.l2_address, 16'h0000);
    rst_n = 1;
  endtask

  typedef struct {
    bit ir; logic [15:0] ia; bit dr; bit dw; logic [15:0] da; logic [127:0] dwd; bit rsp;
    bit e_rd; bit e_wr; logic [15:0] e_addr; logic [127:0] e_wd; bit e_ir; bit e_dr;
  } vec_t;

  function automatic vec_t mk(bit ir, logic [15:0] ia, bit dr, bit dw, logic [15:0] da,
                              logic [127:0] dwd, bit rsp, bit e_rd, bit e_wr,
                              logic [15:0] e_addr, logic [127:0] e_wd, bit e_ir, bit e_dr);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd; v.rsp = rsp;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr; v.e_wd = e_wd; v.e_ir = e_ir; v.e_dr = e_dr;
    return v;
  endfunction

  initial begin
    vec_t vq[$];
    logic [127:0] a5, x5a, z;
    logic [3:0] seq0, seq1;
    int n0, n1;
    a5 = {16{8'hA5}}; x5a = {16{8'h5A}}; z = '0;

    // I read with 4-cycle L2 latency, D writeback, tie, dropped I request, stray l2_resp.
    vq.push_back(mk(1, 16'h0040, 0, 0, 16'h0000, z,   0, 0, 0, 16'h0000, z,   0, 0));
    for (int k = 0; k < 4; k++)
      vq.push_back(mk(1, 16'h0040, 0, 0, 16'h0000, z, 0, 1, 0, 16'h0040, z,   0, 0));
    vq.push_back(mk(1, 16'h0040, 0, 0, 16'h0000, z,   1, 1, 0, 16'h0040, z,   1, 0));
    vq.push_back(mk(0, 16'h0040, 0, 0, 16'h0000, z,   0, 0, 0, 16'h0040, z,   0, 0));
    vq.push_back(mk(0, 16'h0040, 0, 0, 16'h0000, z,   0, 0, 0, 16'h0040, z,   0, 0));
    vq.push_back(mk(0, 16'h0000, 0, 1, 16'h8010, a5,  0, 0, 0, 16'h0040, z,   0, 0));
    vq.push_back(mk(0, 16'h0000, 0, 1, 16'h8010, x5a, 0, 0, 1, 16'h8010, a5,  0, 0));
    vq.push_back(mk(0, 16'h0000, 0, 1, 16'h8010, x5a, 1, 0, 1, 16'h8010, a5,  0, 1));
    vq.push_back(mk(0, 16'h0000, 0, 0, 16'h8010, x5a, 0, 0, 0, 16'h8010, a5,  0, 0));
    vq.push_back(mk(1, 16'h0100, 1, 0, 16'h0200, x5a, 0, 0, 0, 16'h8010, a5,  0, 0));
    vq.push_back(mk(1, 16'h0100, 1, 0, 16'h0200, x5a, 0, 1, 0, 16'h0200, x5a, 0, 0));
    vq.push_back(mk(1, 16'h0100, 1, 0, 16'h0200, x5a, 1, 1, 0, 16'h0200, x5a, 0, 1));
    vq.push_back(mk(1, 16'h0100, 0, 0, 16'h0200, x5a, 0, 0, 0, 16'h0200, x5a, 0, 0));
    vq.push_back(mk(1, 16'h0100, 0, 0, 16'h0200, x5a, 0, 0, 0, 16'h0200, x5a, 0, 0));
    vq.push_back(mk(1, 16'h0100, 0, 0, 16'h0200, x5a, 1, 1, 0, 16'h0100, x5a, 1, 0));
    vq.push_back(mk(0, 16'h0100, 0, 0, 16'h0200, x5a, 0, 0, 0, 16'h0100, x5a, 0, 0));
    vq.push_back(mk(1, 16'h0300, 0, 0, 16'h0200, x5a, 0, 0, 0, 16'h0100, x5a, 0, 0));
    vq.push_back(mk(1, 16'h0300, 0, 0, 16'h0200, x5a, 0, 1, 0, 16'h0300, x5a, 0, 0));
    vq.push_back(mk(1, 16'h0300, 0, 0, 16'h0200, x5a, 0, 1, 0, 16'h0300, x5a, 0, 0));
    vq.push_back(mk(0, 16'h0300, 0, 0, 16'h0200, x5a, 0, 1, 0, 16'h0300, x5a, 0, 0));
    vq.push_back(mk(0, 16'h0300, 0, 0, 16'h0200, x5a, 1, 1, 0, 16'h0300, x5a, 1, 0));
    vq.push_back(mk(0, 16'h0300, 0, 0, 16'h0200, x5a, 0, 0, 0, 16'h0300, x5a, 0, 0));
    vq.push_back(mk(0, 16'h0300, 0, 0, 16'h0200, x5a, 1, 0, 0, 16'h0300, x5a, 0, 0));
    vq.push_back(mk(0, 16'h0300, 0, 0, 16'h0200, x5a, 0, 0, 0, 16'h0300, x5a, 0, 0));

    sat_clr = 0; sat_inc = 0;
    rst_n = 0;
    clear_inputs();
    model_reset();
    #2;
    check_model();
    @(posedge clk); #1;
    rst_n = 1;

    foreach (vq[i]) begin
      i_read = vq[i].ir; i_address = vq[i].ia; d_read = vq[i].dr; d_write = vq[i].dw;
      d_address = vq[i].da; d_wdata = vq[i].dwd; l2_resp = vq[i].rsp;
      l2_rdata = {8{16'(i * 16'h1357)}};
      #3;
      chk($sformatf("tbl%0d_l2_read", i), bus0.l2_read, vq[i].e_rd);
      chk($sformatf("tbl%0d_l2_write", i), bus0.l2_write, vq[i].e_wr);
      chk($sformatf("tbl%0d_l2_address", i), bus0.l2_address, vq[i].e_addr);
      chk($sformatf("tbl%0d_l2_wdata", i), bus0.l2_wdata, vq[i].e_wd);
      chk($sformatf("tbl%0d_i_resp", i), bus0.i_resp, vq[i].e_ir);
      chk($sformatf("tbl%0d_d_resp", i), bus0.d_resp, vq[i].e_dr);
      check_model();
      @(posedge clk);
      model_update();
      #1;
    end

    // Asynchronous reset in the middle of a D writeback, then a tie on release.
    clear_inputs();
    d_write = 1; d_address = 16'h1234; d_wdata = {4{32'hDEADBEEF}};
    cycle_check();
    cycle_check();
    #1;
    l2_resp = 1;
    rst_n = 0;
    #1;
    chk("async_rst_l2_write0", bus0.l2_write, 1'b0);
    chk("async_rst_l2_write1", bus1.l2_write, 1'b0);
    chk("async_rst_l2_address0", bus0.l2_address, 16'h0000);
    chk("async_rst_d_resp1", bus1.d_resp, 1'b0);
    model_reset();
    l2_resp = 0; d_write = 0;
    i_read = 1; i_address = 16'h0777; d_read = 1; d_address = 16'h0888;
    #1;
    rst_n = 1;
    check_model();
    @(posedge clk); model_update(); #1;
    chk("post_rst_tie_addr0", bus0.l2_address, 16'h0888);
    chk("post_rst_tie_addr1", bus1.l2_address, 16'h0888);
    d_read = 0; l2_resp = 1;
    cycle_check();
    l2_resp = 0;
    cycle_check();
    cycle_check();
    chk("post_rst_i_read1", bus1.l2_read, 1'b1);
    chk("post_rst_i_addr1", bus1.l2_address, 16'h0777);
    l2_resp = 1; i_read = 0;
    cycle_check();
    l2_resp = 0;
    cycle_check();

    // Persistent ties with an immediate L2: RR_EN=1 alternates D,I,D,I; RR_EN=0 always D.
    do_reset();
    i_read = 1; d_read = 1; l2_resp = 1;
    seq0 = '0; seq1 = '0; n0 = 0; n1 = 0;
    for (int c = 0; c < 12; c++) begin
      #3;
      if ((bus0.i_resp || bus0.d_resp) && n0 < 4) begin seq0[n0] = bus0.d_resp; n0++; end
      if ((bus1.i_resp || bus1.d_resp) && n1 < 4) begin seq1[n1] = bus1.d_resp; n1++; end
      check_model();
      @(posedge clk); model_update(); #1;
    end
    chk("rr0_grant_count", 128'(n0), 128'(4));
    chk("rr1_grant_count", 128'(n1), 128'(4));
    chk("rr0_order", seq0, 4'b1111);
    chk("rr1_order", seq1, 4'b0101);
    clear_inputs();
    cycle_check();

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      i_read      = ($urandom_range(0, 2) != 0);
      d_read      = 1'($urandom_range(0, 1));
      d_write     = ($urandom_range(0, 4) == 0);
      i_address   = 16'($urandom);
      d_address   = 16'($urandom);
      d_wdata     = {$urandom, $urandom, $urandom, $urandom};
      l2_rdata    = {$urandom, $urandom, $urandom, $urandom};
      l2_resp     = ($urandom_range(0, 3) == 0);
      stats_clear = ($urandom_range(0, 63) == 0);
      cycle_check();
    end
    clear_inputs();
    cycle_check();

`ifdef CACHE_ARBITER_STATS_EN
    // Three ties followed by two D-only requests.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      i_read = (k < 3); d_read = 1;
      cycle_check();
      i_read = 0; d_read = 0; l2_resp = 1;
      cycle_check();
      l2_resp = 0;
      cycle_check();
    end
    chk("stats_d_grants0", dg0, 16'd5);
    chk("stats_conflicts0", cf0, 16'd3);
    chk("stats_i_grants0", ig0, 16'd0);
    chk("stats_d_grants1", dg1, 16'd4);
    chk("stats_i_grants1", ig1, 16'd1);
    chk("stats_conflicts1", cf1, 16'd3);
    d_read = 1; stats_clear = 1;
    cycle_check();
    stats_clear = 0; d_read = 0;
    chk("stats_clear_d0", dg0, 16'd0);
    chk("stats_clear_c0", cf0, 16'd0);
    chk("stats_clear_i1", ig1, 16'd0);
    l2_resp = 1;
    cycle_check();
    l2_resp = 0;
    cycle_check();
`endif

    // Saturation and clear priority, exercised on a narrow counter instance.
    chk("sat_start", sat_count, 4'd0);
    sat_inc = 1;
    for (int k = 0; k < 10; k++) begin @(posedge clk); #1; end
    chk("sat_mid", sat_count, 4'd10);
    for (int k = 0; k < 10; k++) begin @(posedge clk); #1; end
    chk("sat_hold", sat_count, 4'd15);
    sat_clr = 1;
    @(posedge clk); #1;
    chk("sat_clr_priority", sat_count, 4'd0);
    sat_clr = 0; sat_inc = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
Shares the single L2/physical-memory line port between the instruction-cache miss path and the data-cache miss path of the pipelined LC-3b core. Each cache presents line-granular read or write requests. The arbiter grants one requester at a time, latches its address and write data, and drives the L2 port until `l2_resp`. It routes the response and read line back to the granted requester only. It sits between the split L1 caches and L2, below the fetch and mem_control request/response handshakes.

Parameters:
ADDR_W, 16, byte address width (`lc3b_word`).
LINE_W, 128, cache line width in bits.
RR_EN, 0, tie policy: 0 = data side always wins ties; 1 = round-robin on ties.

Ports:
clk  in  1  single clock; everything on posedge
rst_n  in  1  asynchronous, active-low reset
i_read  in  1  I-cache line read request; held until i_resp
i_address  in  ADDR_W  I-cache line address
i_rdata  out  LINE_W  line returned to I-cache
i_resp  out  1  one-cycle completion pulse to I-cache
d_read  in  1  D-cache line read request
d_write  in  1  D-cache line write (writeback) request
d_address  in  ADDR_W  D-cache line address
d_wdata  in  LINE_W  D-cache writeback line
d_rdata  out  LINE_W  line returned to D-cache
d_resp  out  1  one-cycle completion pulse to D-cache
l2_read  out  1  L2 read strobe, held until l2_resp
l2_write  out  1  L2 write strobe, held until l2_resp
l2_address  out  ADDR_W  latched address of the granted request
l2_wdata  out  LINE_W  latched write line
l2_rdata  in  LINE_W  L2 read line
l2_resp  in  1  L2 completion, single cycle

Behaviour:
- FSM states: IDLE, SERVE_I, SERVE_D, DONE.
- Reset (asynchronous, any state, including mid-transaction):
  - state goes to IDLE; last_grant goes to I.
  - l2_read, l2_write, i_resp and d_resp go to 0; l2_address, l2_wdata go to 0.
  - A partially issued L2 transaction is abandoned; L2 is reset by the same rst_n.
- IDLE:
  - d_pend = d_read | d_write; i_pend = i_read.
  - Only one side pending: grant that side.
  - Both pending, RR_EN=0: grant D.
  - Both pending, RR_EN=1: grant the side not equal to last_grant.
  - On grant, latch address, wdata (D side only) and op (write if d_write, else read); update last_grant; enter SERVE_x next edge.
  - No L2 strobe is asserted in IDLE.
- SERVE_x:
  - l2_read/l2_write are driven from the latched op; l2_address/l2_wdata from the latches. Strobes are registered outputs.
  - On the l2_resp cycle, x_resp=1 combinationally and x_rdata=l2_rdata; the other side's resp stays 0.
  - The next edge enters DONE.
- DONE: all strobes and resps are 0 for one cycle so the requester can drop its request. Returns to IDLE.
- Latency: request in cycle 0, l2 strobe in cycle 1, resp in the l2_resp cycle. Minimum turnaround is 3 cycles plus L2 latency.
- i_rdata/d_rdata: l2_rdata is passed through to both outputs at all times; only the resp is qualified.
- d_read and d_write together is illegal; write wins.
- Requester input changes during SERVE are ignored; the latched values are used.
- Requester drops its request before resp (e.g. fetch flush): the L2 transaction still completes and x_resp still pulses. The requester discards it.
- l2_resp in IDLE or DONE is ignored.
- Back-to-back requests from the same side are allowed, with no starvation guarantee when RR_EN=0.

Optional Feature:
CACHE_ARBITER_STATS_EN: adds ports stats_clear (in, 1), i_grants, d_grants, conflicts (out, 16 each).
- i_grants/d_grants count grants per side; conflicts counts IDLE cycles with both sides pending.
- All three saturate at 16'hFFFF and clear on rst_n or stats_clear. stats_clear takes priority over a same-cycle increment.
- Counter values are readable through the MMIO counter block.
- Without the macro, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- lc3b_types gains `lc3b_line` (LINE_W logic vector) and `arb_state_t` enum {IDLE, SERVE_I, SERVE_D, DONE}.
- One sub-module, `sat_counter16` (clk, rst_n, clr, inc, count), instantiated three times under the macro.
- Grant logic stays inline.

Test Plan:
- Reset then i_read=1, i_address=16'h0040, l2_resp 4 cycles after strobe: l2_read rises in cycle 1 with l2_address=16'h0040. i_resp pulses once with i_rdata=l2_rdata. d_resp stays 0. DONE gap of 1 cycle.
- d_write=1, d_address=16'h8010, d_wdata=128'hA5..A5: l2_write=1, l2_wdata matches; d_wdata changed mid-SERVE does not affect l2_wdata.
- i_read and d_read asserted the same cycle, RR_EN=0: D served first, I second. RR_EN=1 with repeated ties: grants alternate D, I, D, I.
- i_read dropped 2 cycles into SERVE_I: l2_read held to l2_resp, i_resp still pulses, then IDLE.
- rst_n low mid-SERVE_D: strobes low immediately (asynchronous); after release, pending i_read is granted (last_grant=I, so with RR_EN=1 a tie grants D).
- With CACHE_ARBITER_STATS_EN: 3 conflicts and 5 D grants give d_grants=5, conflicts=3. Preload to 16'hFFFF saturates. stats_clear zeros all three.
